// File: rtl/star_pkg.sv
`default_nettype none
// ============================================================================
// Module      : star_pkg
// Description : Shared constants and state encoding for the STAR softmax
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package star_pkg;

  // One-hot vector width of the CAM/LUT interfaces
  localparam int LUT_LEN    = 64;
  // xi maps to one-hot bit (xi + XI_OFFSET)
  localparam int XI_OFFSET  = 20;
  // (xi - max) maps to one-hot bit (diff + SUB_OFFSET)
  localparam int SUB_OFFSET = 50;
  // Default matrix geometry
  localparam int INPUT_LEN  = 16;
  localparam int N_ROWS     = 16;
  localparam int ADDR_W     = 9;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LAST    = 3'd2,
    GAP1    = 3'd3,
    FINDSUB = 3'd4,
    GAP2    = 3'd5,
    EXP     = 3'd6,
    DONE    = 3'd7
  } state_e;

  // Counter width that never collapses to zero bits
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/star_onehot_max.sv
`default_nettype none
// ============================================================================
// Module      : star_onehot_max
// Description : OR-accumulates one-hot codes and isolates the highest set
//               bit, giving the running maximum in one-hot form.
// Revision    : 1.0 - initial release
// ============================================================================
module star_onehot_max import star_pkg::*; #(
  parameter int WIDTH = LUT_LEN
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] onehot_i,
  output logic [WIDTH-1:0] max_o
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;

  // Clear has priority so a new row never inherits the previous maximum
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q | onehot_i;
    end
  end

  // Accumulator register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Ascending scan: the last set bit seen (the highest) wins
  always_comb begin
    max_o = '0;
    for (int b = 0; b < WIDTH; b++) begin
      if (acc_q[b]) begin
        max_o    = '0;
        max_o[b] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/star_softmax.sv
`default_nettype none
// ============================================================================
// Module      : star_softmax
// Description : Row sequencer for the STAR CAM/LUT softmax datapath. Each row
//               is fetched, stored/encoded (CAMSUB), max-subtracted (FindSub)
//               and sent to the exp LUT (EXP), with a one-cycle gap between
//               phases so the external memory counters can rewind.
// Revision    : 1.0 - initial release
// ============================================================================
module star_softmax #(
  parameter int INPUT_LEN = star_pkg::INPUT_LEN,
  parameter int N_ROWS    = star_pkg::N_ROWS,
  parameter int LUT_LEN   = star_pkg::LUT_LEN,
  parameter int ADDR_W    = star_pkg::ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         data,
  output logic               data_req,
  output logic [ADDR_W-1:0]  data_addr,
  input  logic [LUT_LEN-1:0] i_xi_MV,
  output logic               CAMSUB_req,
  output logic [7:0]         xi,
  output logic [LUT_LEN-1:0] o_xmax_MV,
  output logic [LUT_LEN-1:0] o_xi_MV,
  output logic               FindSub_req,
  input  logic [LUT_LEN-1:0] i_sub_MV,
  output logic               EXP_req,
  input  logic [31:0]        exp,
  input  logic [31:0]        Sum_exp,
  output logic [LUT_LEN-1:0] o_sub_MV,
  output logic               finish
);
  import star_pkg::*;

  localparam int                K_W      = cnt_width(INPUT_LEN);
  localparam int                ROW_W    = cnt_width(N_ROWS);
  localparam logic [K_W-1:0]    K_LAST   = K_W'(INPUT_LEN - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(N_ROWS - 1);

  state_e               state_q;
  logic [K_W-1:0]       k_q;
  logic [ROW_W-1:0]     row_q;
  logic                 data_req_q;
  logic [ADDR_W-1:0]    data_addr_q;
  logic                 camsub_req_q;
  logic [7:0]           xi_q;
  logic                 findsub_req_q;
  logic                 exp_req_q;
  logic                 finish_q;
  logic [LUT_LEN-1:0]   o_xi_mv_q;
  logic                 w_phase_end;
  logic                 w_acc_clr;
  logic                 w_unused_lut;

  // The LUT value inputs are reserved; fold them into an intentionally unused net
  assign w_unused_lut = ^{exp, Sum_exp};

  assign w_phase_end = (k_q == K_LAST);

  // Accumulator clears on every edge that enters FETCH (first row or next row)
  assign w_acc_clr = (state_q == IDLE) ||
                     ((state_q == EXP) && w_phase_end && (row_q != ROW_LAST));

  // Sequencer FSM with all strobes registered for the next state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      k_q           <= '0;
      row_q         <= '0;
      data_req_q    <= 1'b0;
      data_addr_q   <= '0;
      camsub_req_q  <= 1'b0;
      xi_q          <= '0;
      findsub_req_q <= 1'b0;
      exp_req_q     <= 1'b0;
      finish_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q     <= FETCH;
          k_q         <= '0;
          row_q       <= '0;
          data_req_q  <= 1'b1;
          data_addr_q <= '0;
        end
        FETCH: begin
          // Element k lands in xi and is strobed to CAMSUB one cycle later
          xi_q         <= data;
          camsub_req_q <= 1'b1;
          if (w_phase_end) begin
            state_q    <= LAST;
            data_req_q <= 1'b0;
            k_q        <= '0;
          end else begin
            k_q         <= k_q + K_W'(1);
            data_addr_q <= data_addr_q + ADDR_W'(1);
          end
        end
        LAST: begin
          camsub_req_q <= 1'b0;
          state_q      <= GAP1;
        end
        GAP1: begin
          state_q       <= FINDSUB;
          findsub_req_q <= 1'b1;
          k_q           <= '0;
        end
        FINDSUB: begin
          if (w_phase_end) begin
            findsub_req_q <= 1'b0;
            state_q       <= GAP2;
            k_q           <= '0;
          end else begin
            k_q <= k_q + K_W'(1);
          end
        end
        GAP2: begin
          state_q   <= EXP;
          exp_req_q <= 1'b1;
          k_q       <= '0;
        end
        EXP: begin
          if (w_phase_end) begin
            exp_req_q <= 1'b0;
            k_q       <= '0;
            if (row_q == ROW_LAST) begin
              state_q  <= DONE;
              finish_q <= 1'b1;
            end else begin
              // Next row starts right after the previous row's last address
              row_q       <= row_q + ROW_W'(1);
              state_q     <= FETCH;
              data_req_q  <= 1'b1;
              data_addr_q <= data_addr_q + ADDR_W'(1);
            end
          end else begin
            k_q <= k_q + K_W'(1);
          end
        end
        DONE: begin
          finish_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Capture the CAMSUB encoding of each element while it is strobed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_xi_mv_q <= '0;
    end else if (camsub_req_q) begin
      o_xi_mv_q <= i_xi_MV;
    end
  end

  star_onehot_max #(
    .WIDTH (LUT_LEN)
  ) u_max (
    .clk_i    (clk),
    .rst_ni   (reset),
    .clr_i    (w_acc_clr),
    .en_i     (camsub_req_q),
    .onehot_i (i_xi_MV),
    .max_o    (o_xmax_MV)
  );

  assign data_req    = data_req_q;
  assign data_addr   = data_addr_q;
  assign CAMSUB_req  = camsub_req_q;
  assign xi          = xi_q;
  assign o_xi_MV     = o_xi_mv_q;
  assign FindSub_req = findsub_req_q;
  assign EXP_req     = exp_req_q;
  assign finish      = finish_q;
  // AND-gating keeps anything driven on i_sub_MV outside EXP off the LUT bus
  assign o_sub_MV    = i_sub_MV & {LUT_LEN{exp_req_q}};

endmodule
`default_nettype wire

// File: tb/tb_star_softmax.sv
`default_nettype none
// ============================================================================
// Module      : tb_star_softmax
// Description : Directed bench for star_softmax: a 4x2 instance for detailed
//               per-cycle behaviour and a 16x16 instance for full-run timing
//               and mid-run reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_star_softmax;

  localparam logic [63:0] ALL1 = '1;

  logic clk;
  int   n_pass;
  int   n_total;
  int   cyc4;
  int   cyc16;

  logic        reset4, reset16;
  logic [7:0]  data4, data16;
  logic        dr4, dr16;
  logic [8:0]  addr4, addr16;
  logic [63:0] i_xi4, i_xi16, o_xmax4, o_xmax16, o_xi4, o_xi16;
  logic [63:0] i_sub4, i_sub16, o_sub4, o_sub16;
  logic        cs4, cs16, fs4, fs16, ex4, ex16, fin4, fin16;
  logic [7:0]  xi4, xi16;
  logic [31:0] zero32;

  logic [7:0]  mem4 [8];
  logic [63:0] sub_tab [4];

  function automatic logic [63:0] oh(input int b);
    return (b >= 0 && b < 64) ? (64'd1 << b) : 64'd0;
  endfunction

  star_softmax #(.INPUT_LEN(4), .N_ROWS(2), .LUT_LEN(64), .ADDR_W(9)) dut4 (
    .clk(clk), .reset(reset4), .data(data4), .data_req(dr4), .data_addr(addr4),
    .i_xi_MV(i_xi4), .CAMSUB_req(cs4), .xi(xi4), .o_xmax_MV(o_xmax4),
    .o_xi_MV(o_xi4), .FindSub_req(fs4), .i_sub_MV(i_sub4), .EXP_req(ex4),
    .exp(zero32), .Sum_exp(zero32), .o_sub_MV(o_sub4), .finish(fin4)
  );

  star_softmax #(.INPUT_LEN(16), .N_ROWS(16), .LUT_LEN(64), .ADDR_W(9)) dut16 (
    .clk(clk), .reset(reset16), .data(data16), .data_req(dr16), .data_addr(addr16),
    .i_xi_MV(i_xi16), .CAMSUB_req(cs16), .xi(xi16), .o_xmax_MV(o_xmax16),
    .o_xi_MV(o_xi16), .FindSub_req(fs16), .i_sub_MV(i_sub16), .EXP_req(ex16),
    .exp(zero32), .Sum_exp(zero32), .o_sub_MV(o_sub16), .finish(fin16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External memory / CAM models
  assign zero32  = 32'd0;
  assign data4   = mem4[addr4[2:0]];
  assign data16  = {4'd0, addr16[3:0]};
  assign i_sub16 = '0;
  always_comb i_xi4  = cs4  ? oh($signed(xi4)  + 20) : 64'd0;
  always_comb i_xi16 = cs16 ? oh($signed(xi16) + 20) : 64'd0;
  // Difference codes during row-0 EXP cycles; all-ones elsewhere to expose gating
  always_comb i_sub4 = (cyc4 >= 12 && cyc4 <= 15) ? sub_tab[2'(cyc4 - 12)] : ALL1;

  task automatic tick4();
    @(posedge clk); #1; cyc4 = cyc4 + 1; #1;
  endtask

  task automatic tick16();
    @(posedge clk); #1; cyc16 = cyc16 + 1; #1;
  endtask

  task automatic restart4();
    reset4 = 1'b0; cyc4 = 0;
    @(posedge clk); #1; reset4 = 1'b1; #1;
  endtask

  task automatic restart16();
    reset16 = 1'b0; cyc16 = 0;
    @(posedge clk); #1; reset16 = 1'b1; #1;
  endtask

  task automatic test_reset();
    reset4 = 1'b0; reset16 = 1'b0; cyc4 = 0; cyc16 = 0;
    repeat (2) @(posedge clk);
    #2;
    n_total++;
    if ({dr4, cs4, fs4, ex4, fin4} !== 5'd0)
      $display("FAIL reset_strobes: got %b want 00000", {dr4, cs4, fs4, ex4, fin4});
    else n_pass++;
    n_total++;
    if (addr4 !== 9'd0) $display("FAIL reset_addr: got %0d want 0", addr4); else n_pass++;
    n_total++;
    if (xi4 !== 8'd0) $display("FAIL reset_xi: got %0h want 0", xi4); else n_pass++;
    n_total++;
    if (o_xmax4 !== 64'd0) $display("FAIL reset_xmax: got %h want 0", o_xmax4); else n_pass++;
    n_total++;
    if (o_xi4 !== 64'd0) $display("FAIL reset_o_xi: got %h want 0", o_xi4); else n_pass++;
    n_total++;
    if (o_sub4 !== 64'd0) $display("FAIL reset_o_sub: got %h want 0", o_sub4); else n_pass++;
  endtask

  task automatic test_fetch();
    int         ncs;
    logic [8:0] exp_addr;
    logic       exp_dr, exp_cs;
    ncs = 0;
    restart4();
    for (int c = 1; c <= 6; c++) begin
      tick4();
      exp_dr   = (c <= 4);
      exp_cs   = (c >= 2 && c <= 5);
      exp_addr = (c <= 4) ? 9'(c - 1) : 9'd3;
      if (cs4) ncs++;
      n_total++;
      if (dr4 !== exp_dr) $display("FAIL fetch_data_req c%0d: got %b want %b", c, dr4, exp_dr);
      else n_pass++;
      n_total++;
      if (addr4 !== exp_addr) $display("FAIL fetch_addr c%0d: got %0d want %0d", c, addr4, exp_addr);
      else n_pass++;
      n_total++;
      if (cs4 !== exp_cs) $display("FAIL fetch_camsub c%0d: got %b want %b", c, cs4, exp_cs);
      else n_pass++;
    end
    n_total++;
    if (ncs !== 4) $display("FAIL camsub_count: got %0d want 4", ncs); else n_pass++;
  endtask

  task automatic test_max();
    logic [7:0] xi_t [6];
    int         oxb [6];
    int         mxb [6];
    xi_t = '{8'h00, 8'h03, 8'hFB, 8'h0A, 8'h00, 8'h00};
    oxb  = '{-1, -1, 23, 15, 30, 20};
    mxb  = '{-1, -1, 23, 23, 30, 30};
    restart4();
    for (int c = 1; c <= 16; c++) begin
      tick4();
      if (c <= 6) begin
        n_total++;
        if (xi4 !== xi_t[c-1]) $display("FAIL xi c%0d: got %0h want %0h", c, xi4, xi_t[c-1]);
        else n_pass++;
        n_total++;
        if (o_xi4 !== oh(oxb[c-1])) $display("FAIL o_xi c%0d: got %h want %h", c, o_xi4, oh(oxb[c-1]));
        else n_pass++;
        n_total++;
        if (o_xmax4 !== oh(mxb[c-1])) $display("FAIL xmax c%0d: got %h want %h", c, o_xmax4, oh(mxb[c-1]));
        else n_pass++;
      end
      if (c == 15) begin
        n_total++;
        if (o_xmax4 !== oh(30)) $display("FAIL xmax_hold: got %h want %h", o_xmax4, oh(30));
        else n_pass++;
      end
      if (c == 16) begin
        n_total++;
        if (o_xmax4 !== 64'd0) $display("FAIL xmax_clear: got %h want 0", o_xmax4);
        else n_pass++;
      end
    end
  endtask

  task automatic test_phases();
    int   viol;
    logic exp_fs, exp_ex;
    viol = 0;
    restart4();
    for (int c = 1; c <= 16; c++) begin
      tick4();
      if (int'(cs4) + int'(fs4) + int'(ex4) > 1) viol++;
      exp_fs = (c >= 7 && c <= 10);
      exp_ex = (c >= 12 && c <= 15);
      n_total++;
      if (fs4 !== exp_fs) $display("FAIL findsub c%0d: got %b want %b", c, fs4, exp_fs);
      else n_pass++;
      n_total++;
      if (ex4 !== exp_ex) $display("FAIL exp_req c%0d: got %b want %b", c, ex4, exp_ex);
      else n_pass++;
      if (c == 6 || c == 11) begin
        n_total++;
        if ({dr4, cs4, fs4, ex4} !== 4'd0)
          $display("FAIL gap c%0d: got %b want 0000", c, {dr4, cs4, fs4, ex4});
        else n_pass++;
      end
    end
    n_total++;
    if (viol !== 0) $display("FAIL strobe_onehot: got %0d overlaps want 0", viol); else n_pass++;
  endtask

  task automatic test_exp_sub();
    logic [63:0] exp_sub;
    restart4();
    for (int c = 1; c <= 32; c++) begin
      tick4();
      if (c <= 16) begin
        exp_sub = (c >= 12 && c <= 15) ? sub_tab[2'(c - 12)] : 64'd0;
        n_total++;
        if (o_sub4 !== exp_sub) $display("FAIL o_sub c%0d: got %h want %h", c, o_sub4, exp_sub);
        else n_pass++;
      end
      if (c >= 30) begin
        n_total++;
        if (fin4 !== (c >= 31)) $display("FAIL finish4 c%0d: got %b want %b", c, fin4, (c >= 31));
        else n_pass++;
      end
      if (c == 32) begin
        n_total++;
        if (addr4 !== 9'd7) $display("FAIL done_addr4: got %0d want 7", addr4); else n_pass++;
        n_total++;
        if ({dr4, cs4, fs4, ex4} !== 4'd0)
          $display("FAIL done_strobes4: got %b want 0000", {dr4, cs4, fs4, ex4});
        else n_pass++;
      end
    end
  endtask

  task automatic test_full_run();
    int         first;
    int         viol;
    logic [8:0] last;
    first = -1; viol = 0; last = '0;
    restart16();
    for (int c = 1; c <= 830; c++) begin
      tick16();
      if (dr16) last = addr16;
      if (fin16 && first < 0) first = c;
      if (first > 0 && ({dr16, cs16, fs16, ex16} !== 4'd0 || fin16 !== 1'b1)) viol++;
    end
    n_total++;
    if (first !== 817) $display("FAIL finish_cycle: got %0d want 817", first); else n_pass++;
    n_total++;
    if (last !== 9'd255) $display("FAIL last_addr: got %0d want 255", last); else n_pass++;
    n_total++;
    if (addr16 !== 9'd255) $display("FAIL done_addr16: got %0d want 255", addr16); else n_pass++;
    n_total++;
    if (viol !== 0) $display("FAIL after_finish: got %0d bad cycles want 0", viol); else n_pass++;
  endtask

  task automatic test_reset_mid();
    restart16();
    for (int c = 1; c <= 280; c++) tick16();
    n_total++;
    if (fs16 !== 1'b1) $display("FAIL row5_findsub: got %b want 1", fs16); else n_pass++;
    n_total++;
    if (addr16 !== 9'd95) $display("FAIL row5_addr: got %0d want 95", addr16); else n_pass++;
    #1 reset16 = 1'b0;
    #1;
    n_total++;
    if ({dr16, cs16, fs16, ex16, fin16} !== 5'd0)
      $display("FAIL mid_reset_strobes: got %b want 00000", {dr16, cs16, fs16, ex16, fin16});
    else n_pass++;
    n_total++;
    if (addr16 !== 9'd0) $display("FAIL mid_reset_addr: got %0d want 0", addr16); else n_pass++;
    n_total++;
    if ({xi16, o_xmax16, o_xi16} !== '0)
      $display("FAIL mid_reset_data: got %h/%h/%h want 0", xi16, o_xmax16, o_xi16);
    else n_pass++;
    #1 reset16 = 1'b1;
    tick16();
    n_total++;
    if ({dr16, addr16} !== {1'b1, 9'd0})
      $display("FAIL restart_first: got req=%b addr=%0d want req=1 addr=0", dr16, addr16);
    else n_pass++;
    tick16();
    n_total++;
    if (addr16 !== 9'd1) $display("FAIL restart_second: got %0d want 1", addr16); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc4 = 0; cyc16 = 0;
    reset4 = 1'b0; reset16 = 1'b0;
    mem4    = '{8'h03, 8'hFB, 8'h0A, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    sub_tab = '{oh(43), oh(35), oh(50), oh(40)};
    test_reset();
    test_fetch();
    test_max();
    test_phases();
    test_exp_sub();
    test_full_run();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/star_softmax.md
Name: star_softmax

Overview:
- Sequencer for the STAR CAM/LUT-based softmax datapath.
- Streams an input matrix row by row from external memory and drives each row through three external phases: CAMSUB (store xi, one-hot encode), FindSub (xi − max), and EXP (one-hot of the difference to the exp LUT).
- Tracks the row maximum in one-hot form and asserts finish after the last row.

Parameters:
- INPUT_LEN, 16, elements per row; legal values 16 or 4.
- N_ROWS, 16, rows per run; N_INPUT = INPUT_LEN*N_ROWS (256 or 64).
- LUT_LEN, 64, one-hot vector width. xi maps to bit xi+20; difference maps to bit diff+50.
- ADDR_W, 9, data_addr width.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-low reset.
- data, input, 8, signed element; valid before the posedge ending a data_req cycle.
- data_req, output, 1, memory read request.
- data_addr, output, ADDR_W, element address = row*INPUT_LEN + k.
- i_xi_MV, input, LUT_LEN, one-hot code of current xi from CAMSUB memory.
- CAMSUB_req, output, 1, xi valid / store-and-encode strobe.
- xi, output, 8, signed element presented to CAMSUB memory.
- o_xmax_MV, output, LUT_LEN, one-hot running maximum of current row.
- o_xi_MV, output, LUT_LEN, last registered i_xi_MV.
- FindSub_req, output, 1, subtract phase strobe.
- i_sub_MV, input, LUT_LEN, one-hot code of (xi − max) from CAM memory.
- EXP_req, output, 1, exp phase strobe.
- exp, input, 32, LUT exp value (reserved; no output depends on it).
- Sum_exp, input, 32, LUT sum value (reserved; no output depends on it).
- o_sub_MV, output, LUT_LEN, one-hot difference forwarded to the LUT.
- finish, output, 1, run complete.

Behaviour:
- Reset (reset=0, async):
  - All outputs 0.
  - State IDLE; row=0, k=0.
  - Internal max accumulator cleared.
- IDLE: leaves on the first posedge after reset release and enters FETCH with row=0.
- FETCH (INPUT_LEN cycles):
  - data_req=1; data_addr=row*INPUT_LEN+k, k=0..INPUT_LEN-1.
  - Each posedge registers data into xi.
  - CAMSUB_req=1 from the second FETCH cycle onward.
- LAST (1 cycle): data_req=0; CAMSUB_req=1 with the final xi.
  - CAMSUB_req is therefore high exactly INPUT_LEN consecutive cycles, element k in the k-th of them.
- Max tracking:
  - At every posedge where CAMSUB_req was high: o_xi_MV <= i_xi_MV; acc <= acc | i_xi_MV.
  - o_xmax_MV = highest set bit of acc, isolated.
  - acc clears on entry to FETCH of each row.
  - o_xmax_MV holds from end of LAST until the next row's FETCH.
- GAP1 (1 cycle): all request strobes low. Required so the external CAMSUB counter returns to 0.
- FINDSUB (INPUT_LEN cycles): FindSub_req=1. The external memory emits xi[k] − max.
- GAP2 (1 cycle): all strobes low. Required so the CAM counter returns to 0.
- EXP (INPUT_LEN cycles):
  - EXP_req=1.
  - o_sub_MV = i_sub_MV combinationally during EXP, 0 otherwise.
  - No x/z ever propagates onto o_sub_MV.
- After EXP: if row < N_ROWS-1, row++ and go to FETCH. Otherwise go to DONE.
- DONE: finish=1, all strobes 0, data_addr holds last value; held until reset.
- Timing:
  - Per-row latency 3*INPUT_LEN+3 cycles: 51 for INPUT_LEN=16, 15 for INPUT_LEN=4.
  - finish rises 1 + N_ROWS*(3*INPUT_LEN+3) cycles after reset release.
- Strobes are one-hot: at most one of CAMSUB_req, FindSub_req, EXP_req high per cycle. data_req overlaps CAMSUB_req only during FETCH.
- xi is signed 8-bit. Legal range −20..43; out-of-range values are the memory's concern and pass through unchanged.
- Reset mid-operation aborts immediately to IDLE with outputs zeroed. The run restarts from row 0.

Decomposition:
- Shared package star_pkg: LUT_LEN, XI_OFFSET=20, SUB_OFFSET=50, INPUT_LEN, N_ROWS, and the state enum {IDLE, FETCH, LAST, GAP1, FINDSUB, GAP2, EXP, DONE}.
- One sub-module, star_onehot_max: an OR accumulator plus highest-set-bit isolator producing o_xmax_MV.

Test Plan:
- Reset release, INPUT_LEN=4 -> the next cycle has data_req=1, data_addr=0; addresses step 0,1,2,3; CAMSUB_req is high for exactly 4 cycles, starting 1 cycle later.
- Row {3,−5,10,0}:
  - xi follows the data.
  - o_xi_MV takes bits 23, 15, 30, 20 in turn.
  - o_xmax_MV ends as bit 30.
- Same row, EXP phase with i_sub_MV bits 43, 35, 50, 40 -> o_sub_MV equals them in EXP cycles and is 0 in GAP and FETCH cycles.
- Phase spacing -> exactly 1 idle cycle between CAMSUB→FindSub and FindSub→EXP; FindSub_req and EXP_req are each high 4 cycles.
- Full run, INPUT_LEN=16, N_ROWS=16:
  - The last address is 255.
  - finish rises at cycle 1+16*51=817 after reset release and stays high.
  - No strobes after finish.
- Reset asserted during FINDSUB of row 5 -> outputs zero asynchronously; after release, data_addr restarts at 0.
